// File: rtl/interface2_ctrl.sv
// interface2_ctrl: load/recirculate sequencer driving the INTERFACE2 select lines.
// Define INTERFACE2_CTRL_STALL_EN to gate beats on the selected source valid.
module interface2_ctrl #(
  parameter int LOG2N = 6,
  parameter int NUM_PASS = 6,
  localparam int PW = NUM_PASS > 1 ? $clog2(NUM_PASS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          CLR,
  input  logic          EXTN_VALID,
  input  logic          HRMF_VALID,
  output logic          SEL_EXTN,
  output logic          SEL_PERMW,
  output logic          Q_VALID,
  output logic          BUSY,
  output logic          DONE,
  output logic [PW-1:0] PASS_IDX
);
  localparam int BW = LOG2N - 1;
  localparam int IW = BW > 1 ? $clog2(BW) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, PASS, FIN} state_t;
  state_t state;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] pass_idx;
  logic [IW-1:0] perm_idx;
  logic busy, fire;
  assign busy = (state == LOAD) || (state == PASS);
`ifdef INTERFACE2_CTRL_STALL_EN
  assign fire = (state == LOAD && EXTN_VALID) || (state == PASS && HRMF_VALID);
`else
  logic unused_valid;
  assign unused_valid = EXTN_VALID ^ HRMF_VALID;
  assign fire = busy;
`endif
  assign BUSY = busy;
  assign Q_VALID = fire;
  assign DONE = state == FIN;
  assign SEL_EXTN = state == PASS;
  // perm_idx tracks pass_idx mod BW so the swap bit needs no divider
  assign SEL_PERMW = busy & beat_cnt[perm_idx];
  assign PASS_IDX = pass_idx;
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      state <= IDLE;
      beat_cnt <= '0;
      pass_idx <= '0;
      perm_idx <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          state <= LOAD;
          beat_cnt <= '0;
          pass_idx <= '0;
          perm_idx <= '0;
        end
        LOAD, PASS: if (fire) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (&beat_cnt) begin
            if (pass_idx == PW'(NUM_PASS - 1)) begin
              state <= FIN;
              pass_idx <= '0;
              perm_idx <= '0;
            end else begin
              state <= PASS;
              pass_idx <= pass_idx + 1'b1;
              perm_idx <= (perm_idx == IW'(BW - 1)) ? '0 : perm_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interface2_ctrl.sv
// tb_interface2_ctrl: directed checks of frame sequencing, swap pattern, stall, abort and reset.
module tb_interface2_ctrl;
  localparam int B = 32;
  localparam int BW = 5;
`ifdef INTERFACE2_CTRL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  logic CLK = 0;
  logic RST, START, CLR, EXTN_VALID, HRMF_VALID;
  logic SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE;
  logic [2:0] PASS_IDX;
  int checks = 0;
  int failures = 0;

  interface2_ctrl #(.LOG2N(6), .NUM_PASS(6)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CLR(CLR),
    .EXTN_VALID(EXTN_VALID), .HRMF_VALID(HRMF_VALID),
    .SEL_EXTN(SEL_EXTN), .SEL_PERMW(SEL_PERMW), .Q_VALID(Q_VALID),
    .BUSY(BUSY), .DONE(DONE), .PASS_IDX(PASS_IDX)
  );

  always #5 CLK = ~CLK;

  function automatic logic perm(input int beat, input int pass);
    int v;
    v = (beat >> (pass % BW)) & 1;
    return v[0];
  endfunction

  task automatic test_reset();
    RST = 1; START = 0; CLR = 0; EXTN_VALID = 0; HRMF_VALID = 0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE, PASS_IDX} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000", {SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE, PASS_IDX});
    end
    RST = 0;
  endtask

  task automatic test_continuous_frame();
    int p, b;
    EXTN_VALID = 1; HRMF_VALID = 1;
    @(negedge CLK) START = 1;
    for (int c = 0; c < 6 * B; c++) begin
      @(negedge CLK); START = 0; #1;
      p = c / B; b = c % B;
      checks++;
      if ({Q_VALID, BUSY, DONE} !== 3'b110) begin
        failures++;
        $display("FAIL cont_qv_busy_done c=%0d got=%b exp=110", c, {Q_VALID, BUSY, DONE});
      end
      checks++;
      if (SEL_EXTN !== (p != 0)) begin
        failures++;
        $display("FAIL cont_sel_extn c=%0d got=%b exp=%b", c, SEL_EXTN, p != 0);
      end
      checks++;
      if (PASS_IDX !== p[2:0]) begin
        failures++;
        $display("FAIL cont_pass_idx c=%0d got=%0d exp=%0d", c, PASS_IDX, p);
      end
      checks++;
      if (SEL_PERMW !== perm(b, p)) begin
        failures++;
        $display("FAIL cont_sel_permw c=%0d got=%b exp=%b", c, SEL_PERMW, perm(b, p));
      end
    end
    @(negedge CLK); #1;
    checks++;
    if ({DONE, BUSY, Q_VALID, SEL_EXTN, SEL_PERMW} !== 5'b10000) begin
      failures++;
      $display("FAIL cont_done_pulse got=%b exp=10000", {DONE, BUSY, Q_VALID, SEL_EXTN, SEL_PERMW});
    end
    START = 1;
    @(negedge CLK); START = 0; #1;
    checks++;
    if ({DONE, BUSY} !== 2'b00) begin
      failures++;
      $display("FAIL cont_done_one_cycle_fin_start_ignored got=%b exp=00", {DONE, BUSY});
    end
    @(negedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL cont_idle_after got=%b exp=0", BUSY);
    end
  endtask

  task automatic test_stall();
    int fired, held, mp, mb;
    logic in_win, exp_fire;
    fired = 0; held = 0;
    EXTN_VALID = 1; HRMF_VALID = 1;
    @(negedge CLK) START = 1;
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK); START = 0;
      in_win = (fired == 3 * B + 10) && (held < 7);
      HRMF_VALID = !in_win;
      #1;
      exp_fire = in_win ? !STALL : 1'b1;
      mp = fired / B; mb = fired % B;
      checks++;
      if ({Q_VALID, DONE, SEL_EXTN} !== {exp_fire, 1'b0, mp != 0}) begin
        failures++;
        $display("FAIL stall_qv_done_ext t=%0d got=%b exp=%b", t, {Q_VALID, DONE, SEL_EXTN}, {exp_fire, 1'b0, mp != 0});
      end
      checks++;
      if ({PASS_IDX, SEL_PERMW} !== {mp[2:0], perm(mb, mp)}) begin
        failures++;
        $display("FAIL stall_pass_perm t=%0d got=%b exp=%b", t, {PASS_IDX, SEL_PERMW}, {mp[2:0], perm(mb, mp)});
      end
      if (in_win) held++;
      if (exp_fire) fired++;
      if (fired == 6 * B) break;
    end
    HRMF_VALID = 1;
    @(negedge CLK); #1;
    checks++;
    if (DONE !== 1'b1) begin
      failures++;
      $display("FAIL stall_done_timing got=%b exp=1", DONE);
    end
    @(negedge CLK);
  endtask

  task automatic test_clr();
    logic ok;
    EXTN_VALID = 1; HRMF_VALID = 1;
    @(negedge CLK) START = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK); START = (c == 5); #1;
      checks++;
      if ({BUSY, PASS_IDX, SEL_PERMW} !== {1'b1, 3'd0, perm(c, 0)}) begin
        failures++;
        $display("FAIL clr_load_beat c=%0d got=%b exp=%b", c, {BUSY, PASS_IDX, SEL_PERMW}, {1'b1, 3'd0, perm(c, 0)});
      end
    end
    @(negedge CLK); CLR = 1; START = 1; #1;
    checks++;
    if ({Q_VALID, SEL_PERMW} !== {1'b1, perm(20, 0)}) begin
      failures++;
      $display("FAIL clr_beat20 got=%b exp=%b", {Q_VALID, SEL_PERMW}, {1'b1, perm(20, 0)});
    end
    @(negedge CLK); CLR = 0; START = 0; #1;
    checks++;
    if ({SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE, PASS_IDX} !== 8'h00) begin
      failures++;
      $display("FAIL clr_to_idle got=%b exp=00000000", {SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE, PASS_IDX});
    end
    ok = 1;
    repeat (3) begin
      @(negedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b0) ok = 0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL clr_no_done got=%b exp=1", ok);
    end
    @(negedge CLK) START = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); START = 0; #1;
      checks++;
      if ({BUSY, SEL_EXTN, PASS_IDX, SEL_PERMW} !== {2'b10, 3'd0, perm(c, 0)}) begin
        failures++;
        $display("FAIL clr_restart c=%0d got=%b exp=%b", c, {BUSY, SEL_EXTN, PASS_IDX, SEL_PERMW}, {2'b10, 3'd0, perm(c, 0)});
      end
    end
    @(negedge CLK) RST = 1;
    @(negedge CLK) RST = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    EXTN_VALID = 1; HRMF_VALID = 1;
    @(negedge CLK) START = 1;
    for (int c = 0; c < 70; c++) begin
      @(negedge CLK); START = 0;
    end
    #1;
    checks++;
    if (PASS_IDX !== 3'd2) begin
      failures++;
      $display("FAIL rst_mid_in_pass2 got=%0d exp=2", PASS_IDX);
    end
    RST = 1;
    @(negedge CLK); RST = 0; #1;
    checks++;
    if ({SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE, PASS_IDX} !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=00000000", {SEL_EXTN, SEL_PERMW, Q_VALID, BUSY, DONE, PASS_IDX});
    end
    ok = 1;
    repeat (40) begin
      @(negedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b0) ok = 0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_no_done got=%b exp=1", ok);
    end
  endtask

  task automatic test_no_valid();
    int n;
    logic ok;
    EXTN_VALID = 0; HRMF_VALID = 0;
    @(negedge CLK) START = 1;
    n = 0; ok = 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge CLK); START = 0; #1;
      if (DONE === 1'b1) break;
      if (BUSY === 1'b1) n++;
      if (Q_VALID !== (STALL ? 1'b0 : BUSY)) ok = 0;
      if (STALL && t == 49) break;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL novalid_q_valid got=%b exp=1", ok);
    end
    checks++;
    if (STALL ? ({BUSY, PASS_IDX, SEL_PERMW, DONE} !== 6'b100000) : ({DONE, n} !== {1'b1, 32'd192})) begin
      failures++;
      $display("FAIL novalid_frame busy_cycles=%0d done=%b busy=%b pidx=%0d exp_busy_cycles=%0d", n, DONE, BUSY, PASS_IDX, STALL ? 50 : 192);
    end
    @(negedge CLK) RST = 1;
    @(negedge CLK) RST = 0;
  endtask

  initial begin
    test_reset();
    test_continuous_frame();
    test_stall();
    test_clr();
    test_reset_mid_frame();
    test_no_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
